pipeline_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage pipeline around the instruction decoder.
- Tracks in-flight register writes in a per-register countdown scoreboard and detects RAW hazards at decode.
- Drives the decoder's bubble input, PC/IF-ID stall and IF-ID flush.
- Sequences squash slots after taken branches/JAL, and freezes the pipeline while data memory is busy.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 27 ++
 rtl/hazard_scoreboard.sv | 48 ++++
 rtl/pipeline_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the decode-stage hazard controller: pipeline depths,
// FSM encodings, pcSel encodings and the writer-latency helper.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned NUM_REGS    = 16;
    localparam int unsigned REG_ADDR_W  = 4;
    localparam int unsigned WB_DIST     = 3;
    localparam int unsigned LOAD_EXTRA  = 1;
    localparam int unsigned FLUSH_SLOTS = 2;
    localparam int unsigned CNT_W       = 3;
    localparam int unsigned FCNT_W      = (FLUSH_SLOTS > 2) ? $clog2(FLUSH_SLOTS) : 1;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Execute-stage next-PC select encodings
    localparam logic [1:0] PCSEL_SEQ    = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_JAL    = 2'b10;
    localparam logic [1:0] PCSEL_HOLD   = 2'b11;

    // Cycles a freshly issued writer keeps its destination busy
    function automatic logic [CNT_W-1:0] wr_latency(input logic is_load);
        return is_load ? CNT_W'(WB_DIST + LOAD_EXTRA) : CNT_W'(WB_DIST);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: set on issue, count down while the
// pipeline advances, two read ports for the decode sources.
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  issue,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    input  logic                  issue_load,
    input  logic [REG_ADDR_W-1:0] rd1_addr,
    input  logic [REG_ADDR_W-1:0] rd2_addr,
    output logic                  rd1_busy,
    output logic                  rd2_busy,
    output logic [NUM_REGS-1:0]   busy
);

    logic [CNT_W-1:0] cnt [NUM_REGS];

    // A new issue to a register overrides its pending countdown
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else if (!hold) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (issue && (issue_addr == REG_ADDR_W'(r))) begin
                    cnt[r] <= wr_latency(issue_load);
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    assign rd1_busy = busy[rd1_addr];
    assign rd2_busy = busy[rd2_addr];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard and sequencing controller: RAW stalls, post-redirect
// squash slots and whole-pipeline freeze while data memory is busy.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_s1_addr,
    input  logic                  id_s1_used,
    input  logic [REG_ADDR_W-1:0] id_s2_addr,
    input  logic                  id_s2_used,
    input  logic [REG_ADDR_W-1:0] id_d_addr,
    input  logic                  id_wr_en,
    input  logic                  id_is_load,
    input  logic                  ex_redirect,
    input  logic                  mem_busy,
    output logic                  bubble,
    output logic                  pc_stall,
    output logic                  ifid_flush,
    output logic                  pipe_freeze,
    output logic [NUM_REGS-1:0]   busy_regs
);

    localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_SLOTS - 1);

    logic [0:0]          state;
    logic [0:0]          state_nx;
    logic [FCNT_W-1:0]   flush_cnt;
    logic [FCNT_W-1:0]   flush_cnt_nx;
    logic                s1_busy;
    logic                s2_busy;
    logic [NUM_REGS-1:0] sb_busy;
    logic                raw;
    logic                issue;

    assign raw   = id_valid & ((id_s1_used & s1_busy) | (id_s2_used & s2_busy));
    assign issue = id_valid & id_wr_en & ~bubble & ~pipe_freeze;

    hazard_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .hold       (mem_busy),
        .issue      (issue),
        .issue_addr (id_d_addr),
        .issue_load (id_is_load),
        .rd1_addr   (id_s1_addr),
        .rd2_addr   (id_s2_addr),
        .rd1_busy   (s1_busy),
        .rd2_busy   (s2_busy),
        .busy       (sb_busy)
    );

    assign busy_regs = reset ? '0 : sb_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_nx;
            flush_cnt <= flush_cnt_nx;
        end
    end

    // Priority: reset, memory freeze, squash slots / redirect, RAW, empty decode
    always_comb begin
        bubble       = 1'b0;
        pc_stall     = 1'b0;
        ifid_flush   = 1'b0;
        pipe_freeze  = 1'b0;
        state_nx     = state;
        flush_cnt_nx = flush_cnt;

        if (reset) begin
            bubble       = 1'b1;
            pc_stall     = 1'b1;
            state_nx     = ST_RUN;
            flush_cnt_nx = '0;
        end else if (mem_busy) begin
            pipe_freeze = 1'b1;
            pc_stall    = 1'b1;
        end else if (state == ST_FLUSH) begin
            bubble     = 1'b1;
            ifid_flush = 1'b1;
            if (ex_redirect) begin
                flush_cnt_nx = FLUSH_RELOAD;
            end else if (flush_cnt <= FCNT_W'(1)) begin
                state_nx     = ST_RUN;
                flush_cnt_nx = '0;
            end else begin
                flush_cnt_nx = flush_cnt - FCNT_W'(1);
            end
        end else if (ex_redirect) begin
            bubble     = 1'b1;
            ifid_flush = 1'b1;
            // A single squash slot is covered by this cycle alone
            if (FLUSH_SLOTS > 1) begin
                state_nx     = ST_FLUSH;
                flush_cnt_nx = FLUSH_RELOAD;
            end
        end else if (raw) begin
            bubble   = 1'b1;
            pc_stall = 1'b1;
        end else if (!id_valid) begin
            bubble = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a ready-time model of register availability.
module tb_pipeline_hazard_ctrl;

    localparam int T_WB    = 3;
    localparam int T_LX    = 1;
    localparam int T_SLOTS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [3:0]  id_s1_addr = '0;
    logic        id_s1_used = 1'b0;
    logic [3:0]  id_s2_addr = '0;
    logic        id_s2_used = 1'b0;
    logic [3:0]  id_d_addr = '0;
    logic        id_wr_en = 1'b0;
    logic        id_is_load = 1'b0;
    logic        ex_redirect = 1'b0;
    logic        mem_busy = 1'b0;
    logic        bubble;
    logic        pc_stall;
    logic        ifid_flush;
    logic        pipe_freeze;
    logic [15:0] busy_regs;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: advancing-cycle index, per-register ready time, last redirect time
    int uc = 0;
    int ready_at [16];
    int last_redir = -100;

    pipeline_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_s1_addr  (id_s1_addr),
        .id_s1_used  (id_s1_used),
        .id_s2_addr  (id_s2_addr),
        .id_s2_used  (id_s2_used),
        .id_d_addr   (id_d_addr),
        .id_wr_en    (id_wr_en),
        .id_is_load  (id_is_load),
        .ex_redirect (ex_redirect),
        .mem_busy    (mem_busy),
        .bubble      (bubble),
        .pc_stall    (pc_stall),
        .ifid_flush  (ifid_flush),
        .pipe_freeze (pipe_freeze),
        .busy_regs   (busy_regs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic v,
                        input logic [3:0] s1, input logic s1u,
                        input logic [3:0] s2, input logic s2u,
                        input logic [3:0] d, input logic we, input logic ld,
                        input logic rd, input logic mb);
        logic [15:0] e_busy;
        logic        e_bub, e_stall, e_flush, e_frz, flushing, raw_m;
        @(negedge clk);
        reset = rst; id_valid = v; id_s1_addr = s1; id_s1_used = s1u;
        id_s2_addr = s2; id_s2_used = s2u; id_d_addr = d; id_wr_en = we;
        id_is_load = ld; ex_redirect = rd; mem_busy = mb;
        #1;
        for (int r = 0; r < 16; r++) e_busy[r] = (uc < ready_at[r]);
        flushing = (uc > last_redir) && (uc <= last_redir + T_SLOTS - 1);
        raw_m = v & ((s1u & e_busy[s1]) | (s2u & e_busy[s2]));
        e_bub = 1'b0; e_stall = 1'b0; e_flush = 1'b0; e_frz = 1'b0;
        if (rst) begin
            e_bub = 1'b1; e_stall = 1'b1; e_busy = '0;
        end else if (mb) begin
            e_frz = 1'b1; e_stall = 1'b1;
        end else if (flushing || rd) begin
            e_bub = 1'b1; e_flush = 1'b1;
        end else if (raw_m) begin
            e_bub = 1'b1; e_stall = 1'b1;
        end else if (!v) begin
            e_bub = 1'b1;
        end
        check("bubble",      16'(bubble),      16'(e_bub));
        check("pc_stall",    16'(pc_stall),    16'(e_stall));
        check("ifid_flush",  16'(ifid_flush),  16'(e_flush));
        check("pipe_freeze", 16'(pipe_freeze), 16'(e_frz));
        check("busy_regs",   busy_regs,        e_busy);
        // Advance the model to reflect the coming clock edge
        if (rst) begin
            for (int r = 0; r < 16; r++) ready_at[r] = 0;
            last_redir = -100;
        end else if (!mb) begin
            if (v && we && !e_bub) ready_at[d] = uc + T_WB + (ld ? T_LX : 0) + 1;
            if (rd && T_SLOTS > 1) last_redir = uc;
            uc++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int r = 0; r < 16; r++) ready_at[r] = 0;
        // Reset state
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 1, 0, 0, 3, 1, 0, 1, 1);
        // add r3 followed by a consumer of r3
        step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 3, 1, 0, 0, 8, 0, 0, 0, 0);
        // load r5 followed by a consumer on s2
        step(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 5, 1, 9, 0, 0, 0, 0);
        // redirect; writes to r7 during the squash slots must not issue
        step(0, 1, 0, 0, 0, 0, 7, 1, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        step(0, 1, 7, 1, 0, 0, 2, 0, 0, 0, 0);
        // second redirect during the flush extends the squash window
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        // freeze while r3 is counting down
        step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 3, 1, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        // reset during a flush with r4 outstanding
        step(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 4, 1, 1, 1, 2, 1, 0, 0, 0);
        idle(2);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 80),
                 4'($urandom_range(0, 7)), 1'($urandom),
                 4'($urandom_range(0, 7)), 1'($urandom),
                 4'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 15));
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
